// File: rtl/sequenciador_desvio.sv
// sequenciador_desvio
// Multi-cycle PC sequencer and jump controller.
// It performs the fetch handshake with instruction memory, holds the PC and picks the next one.
// The next PC is sequential, a branch, JAL or JALR.
// It also drives the writeback select for the link value (PC+1) and gates the register-write strobe.
// It counts retired instructions.
// Each instruction takes BUSCA -> EXECUTA -> ESCRITA, which is 3 cycles with zero-wait memory.

module sequenciador_desvio #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 13,
   parameter logic [ADDR_WIDTH-1:0] INICIO_PC  = {ADDR_WIDTH{1'b0}}
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  inicia,
   input  logic                  mem_pronto,
   input  logic                  jump_al,
   input  logic                  jalr,
   input  logic                  desvio,
   input  logic                  halt,
   input  logic                  escreve_reg_in,
   input  logic [ADDR_WIDTH-1:0] alvo_jal,
   input  logic [DATA_WIDTH-1:0] alvo_jalr,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] proximo_pc,
   output logic                  busca_req,
   output logic                  sel_jal,
   output logic                  escreve_reg,
   output logic                  parado,
   output logic [DATA_WIDTH-1:0] instr_retiradas
);

   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      BUSCA   = 3'd1,
      EXECUTA = 3'd2,
      ESCRITA = 3'd3,
      PARADO  = 3'd4
   } estado_t;

   localparam logic [ADDR_WIDTH-1:0] PC_UM   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] CONT_UM = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   estado_t               estado_r;
   logic [ADDR_WIDTH-1:0] pc_r;
   logic [ADDR_WIDTH-1:0] pc_alvo_r;     // next PC chosen in EXECUTA, applied at the end of ESCRITA
   logic [DATA_WIDTH-1:0] cont_r;
   logic                  busca_req_r;
   logic                  sel_jal_r;
   logic                  we_r;
   logic                  parado_r;

   logic [ADDR_WIDTH-1:0] proximo_pc_s;
   logic [ADDR_WIDTH-1:0] alvo_sel_s;
   logic                  link_s;
   logic                  unused_alvo_jalr_s;

   // Only the low ADDR_WIDTH bits of the JALR target address instruction memory.
   assign unused_alvo_jalr_s = ^alvo_jalr[DATA_WIDTH-1:ADDR_WIDTH];

   // Sequential successor of the current PC; wraps naturally at 2^ADDR_WIDTH.
   always_comb begin
      proximo_pc_s = pc_r + PC_UM;
   end

   // Next-PC selection with priority jalr > jump_al > desvio > sequential.
   always_comb begin
      link_s     = jump_al | jalr;
      alvo_sel_s = proximo_pc_s;
      if (jalr) begin
         alvo_sel_s = alvo_jalr[ADDR_WIDTH-1:0];
      end else if (jump_al || desvio) begin
         alvo_sel_s = alvo_jal;
      end else begin
         alvo_sel_s = proximo_pc_s;
      end
   end

   // Sequencer FSM: the state, the PC, the retire counter and every registered output.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_r    <= OCIOSO;
         pc_r        <= INICIO_PC;
         pc_alvo_r   <= INICIO_PC;
         cont_r      <= {DATA_WIDTH{1'b0}};
         busca_req_r <= 1'b0;
         sel_jal_r   <= 1'b0;
         we_r        <= 1'b0;
         parado_r    <= 1'b0;
      end else begin
         case (estado_r)
            OCIOSO: begin
               sel_jal_r <= 1'b0;
               we_r      <= 1'b0;
               parado_r  <= 1'b0;
               if (inicia) begin
                  pc_r        <= INICIO_PC;
                  busca_req_r <= 1'b1;
                  estado_r    <= BUSCA;
               end else begin
                  busca_req_r <= 1'b0;
                  estado_r    <= OCIOSO;
               end
            end

            BUSCA: begin
               sel_jal_r <= 1'b0;
               we_r      <= 1'b0;
               parado_r  <= 1'b0;
               // No timeout: a slow memory simply stretches the fetch.
               if (mem_pronto) begin
                  busca_req_r <= 1'b0;
                  estado_r    <= EXECUTA;
               end else begin
                  busca_req_r <= 1'b1;
                  estado_r    <= BUSCA;
               end
            end

            EXECUTA: begin
               busca_req_r <= 1'b0;
               if (halt) begin
                  // Halt retires nothing: PC, counter and write strobe stay untouched.
                  sel_jal_r <= 1'b0;
                  we_r      <= 1'b0;
                  parado_r  <= 1'b1;
                  estado_r  <= PARADO;
               end else begin
                  pc_alvo_r <= alvo_sel_s;
                  sel_jal_r <= link_s;
                  we_r      <= escreve_reg_in | link_s;
                  parado_r  <= 1'b0;
                  estado_r  <= ESCRITA;
               end
            end

            ESCRITA: begin
               // pc still held the old PC during this cycle, so the link value was old pc+1.
               pc_r        <= pc_alvo_r;
               cont_r      <= cont_r + CONT_UM;
               sel_jal_r   <= 1'b0;
               we_r        <= 1'b0;
               parado_r    <= 1'b0;
               busca_req_r <= 1'b1;
               estado_r    <= BUSCA;
            end

            PARADO: begin
               sel_jal_r <= 1'b0;
               we_r      <= 1'b0;
               // Restart keeps the retire counter.
               if (inicia) begin
                  pc_r        <= INICIO_PC;
                  parado_r    <= 1'b0;
                  busca_req_r <= 1'b1;
                  estado_r    <= BUSCA;
               end else begin
                  parado_r    <= 1'b1;
                  busca_req_r <= 1'b0;
                  estado_r    <= PARADO;
               end
            end

            default: begin
               // An illegal encoding recovers to idle with every strobe quiet.
               estado_r    <= OCIOSO;
               busca_req_r <= 1'b0;
               sel_jal_r   <= 1'b0;
               we_r        <= 1'b0;
               parado_r    <= 1'b0;
            end
         endcase
      end
   end

   assign pc              = pc_r;
   assign proximo_pc      = proximo_pc_s;
   assign busca_req       = busca_req_r;
   assign sel_jal         = sel_jal_r;
   assign escreve_reg     = we_r;
   assign parado          = parado_r;
   assign instr_retiradas = cont_r;

endmodule

// File: tb/tb_sequenciador_desvio.sv
// Bench for sequenciador_desvio.
// A per-cycle reference model is checked against the DUT on every falling edge.
// Directed scenarios pin the model with literal values, then randomized instruction streams follow.
`timescale 1ns/1ps

module tb_sequenciador_desvio;

   localparam int AW = 13;
   localparam int DW = 32;
   localparam int PC_MOD = 8192;

   localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_WRITE = 3, P_HALT = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          inicia = 1'b0, mem_pronto = 1'b0;
   logic          jump_al = 1'b0, jalr = 1'b0, desvio = 1'b0, halt = 1'b0, escreve_reg_in = 1'b0;
   logic [AW-1:0] alvo_jal = '0;
   logic [DW-1:0] alvo_jalr = '0;
   logic [AW-1:0] pc, proximo_pc;
   logic          busca_req, sel_jal, escreve_reg, parado;
   logic [DW-1:0] instr_retiradas;

   int checks = 0;
   int errors = 0;
   bit armed = 1'b0;
   int bq_hi = 0;
   int cyc = 0;

   // reference model state
   int          m_ph;
   int          m_pc;
   int          m_nxt;
   logic [31:0] m_cnt;
   bit          m_sel, m_we;

   // values observed during the last ESCRITA (or PARADO) cycle of run_instr
   logic          w_sel, w_we;
   logic [AW-1:0] w_np, w_pc;

   sequenciador_desvio #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INICIO_PC(13'd0)) dut (
      .clock(clock), .reset(reset), .inicia(inicia), .mem_pronto(mem_pronto),
      .jump_al(jump_al), .jalr(jalr), .desvio(desvio), .halt(halt),
      .escreve_reg_in(escreve_reg_in), .alvo_jal(alvo_jal), .alvo_jalr(alvo_jalr),
      .pc(pc), .proximo_pc(proximo_pc), .busca_req(busca_req), .sel_jal(sel_jal),
      .escreve_reg(escreve_reg), .parado(parado), .instr_retiradas(instr_retiradas)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int next_pc_of(int cur, bit j_r, bit j_l, bit br, int t_jal, logic [31:0] t_jalr);
      if (j_r)              return int'(t_jalr & 32'h0000_1FFF);
      else if (j_l || br)   return t_jal;
      else                  return (cur + 1) % PC_MOD;
   endfunction

   // Reference model: one instruction goes fetch (wait for ack), execute (decide), write (retire).
   always @(posedge clock) begin
      if (reset) begin
         m_ph <= P_IDLE; m_pc <= 0; m_cnt <= 32'd0; m_sel <= 1'b0; m_we <= 1'b0;
      end else begin
         case (m_ph)
            P_IDLE:  if (inicia) begin m_pc <= 0; m_ph <= P_FETCH; end
            P_FETCH: if (mem_pronto) m_ph <= P_EXEC;
            P_EXEC:  if (halt) m_ph <= P_HALT;
                     else begin
                        m_nxt <= next_pc_of(m_pc, jalr, jump_al, desvio, int'(alvo_jal), alvo_jalr);
                        m_sel <= jump_al | jalr;
                        m_we  <= escreve_reg_in | jump_al | jalr;
                        m_ph  <= P_WRITE;
                     end
            P_WRITE: begin m_pc <= m_nxt; m_cnt <= m_cnt + 32'd1; m_ph <= P_FETCH; end
            P_HALT:  if (inicia) begin m_pc <= 0; m_ph <= P_FETCH; end
            default: m_ph <= P_IDLE;
         endcase
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (armed) begin
         chk("pc", pc, m_pc);
         chk("proximo_pc", proximo_pc, (m_pc + 1) % PC_MOD);
         chk("busca_req", busca_req, m_ph == P_FETCH);
         chk("sel_jal", sel_jal, (m_ph == P_WRITE) && m_sel);
         chk("escreve_reg", escreve_reg, (m_ph == P_WRITE) && m_we);
         chk("parado", parado, m_ph == P_HALT);
         chk("instr_retiradas", instr_retiradas, m_cnt);
         bq_hi += int'(busca_req);
         cyc++;
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic junk_dec();
      jump_al = 1'($urandom); jalr = 1'($urandom); desvio = 1'($urandom);
      halt = 1'($urandom); escreve_reg_in = 1'($urandom);
      alvo_jal = AW'($urandom); alvo_jalr = $urandom;
   endtask

   // One instruction, entered while fetching; ignored inputs carry random noise.
   task automatic run_instr(input logic jl, input logic jr, input logic dv, input logic hl,
                            input logic wr, input logic [AW-1:0] tj, input logic [DW-1:0] tjr,
                            input int waits);
      for (int i = 0; i < waits; i++) begin
         mem_pronto = 1'b0; junk_dec(); inicia = 1'($urandom); tick();
      end
      mem_pronto = 1'b1; junk_dec(); inicia = 1'($urandom); tick();
      jump_al = jl; jalr = jr; desvio = dv; halt = hl; escreve_reg_in = wr;
      alvo_jal = tj; alvo_jalr = tjr; mem_pronto = 1'($urandom); inicia = 1'($urandom);
      tick();
      w_sel = sel_jal; w_we = escreve_reg; w_np = proximo_pc; w_pc = pc;
      if (hl) begin
         inicia = 1'b0; junk_dec();
      end else begin
         junk_dec(); inicia = 1'($urandom); mem_pronto = 1'($urandom); tick();
      end
      inicia = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, c0;
      reset = 1'b1;
      tick();
      armed = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_pc", pc, 32'd0);
      chk("rst_cnt", instr_retiradas, 32'd0);
      chk("rst_busca", busca_req, 32'd0);
      chk("rst_parado", parado, 32'd0);
      // 1: four sequential instructions, zero-wait memory
      inicia = 1'b1; tick(); inicia = 1'b0;
      b0 = bq_hi; c0 = cyc;
      for (int k = 0; k < 4; k++) run_instr(0, 0, 0, 0, 0, 13'd0, 32'd0, 0);
      chk("s1_pc", pc, 32'd4);
      chk("s1_cnt", instr_retiradas, 32'd4);
      chk("s1_busca_hi", bq_hi - b0, 32'd4);
      chk("s1_cycles", cyc - c0, 32'd12);
      // 2: JAL at pc=5 without a register-write request
      run_instr(0, 0, 0, 0, 0, 13'd0, 32'd0, 0);
      run_instr(1, 0, 0, 0, 0, 13'h40, 32'd0, 0);
      chk("s2_sel", w_sel, 32'd1);
      chk("s2_we", w_we, 32'd1);
      chk("s2_np", w_np, 32'd6);
      chk("s2_oldpc", w_pc, 32'd5);
      chk("s2_pc", pc, 32'h40);
      // 3: at pc=7, jalr and jump_al together; jalr wins and is truncated
      run_instr(1, 0, 0, 0, 0, 13'd7, 32'd0, 0);
      run_instr(1, 1, 0, 0, 0, 13'h10, 32'hFFFF_E123, 0);
      chk("s3_sel", w_sel, 32'd1);
      chk("s3_pc", pc, 32'h123);
      // 4: wrap from 0x1FFF with five wait cycles in fetch
      run_instr(0, 0, 1, 0, 0, 13'h1FFF, 32'd0, 0);
      chk("s4_pc_top", pc, 32'h1FFF);
      b0 = bq_hi; c0 = cyc;
      run_instr(0, 0, 0, 0, 1, 13'h0AA, 32'd0, 5);
      chk("s4_busca_hi", bq_hi - b0, 32'd6);
      chk("s4_cycles", cyc - c0, 32'd8);
      chk("s4_wrap", pc, 32'd0);
      chk("s4_cnt", instr_retiradas, 32'd10);
      // 5: halt, stay halted, then restart
      run_instr(0, 0, 0, 0, 0, 13'd0, 32'd0, 0);
      run_instr(1, 1, 0, 1, 1, 13'h33, 32'h44, 0);
      chk("s5_parado", parado, 32'd1);
      chk("s5_we", w_we, 32'd0);
      repeat (3) begin mem_pronto = 1'($urandom); junk_dec(); tick(); end
      chk("s5_pc", pc, 32'd1);
      chk("s5_cnt", instr_retiradas, 32'd11);
      inicia = 1'b1; tick(); inicia = 1'b0;
      chk("s5_restart_pc", pc, 32'd0);
      chk("s5_restart_busca", busca_req, 32'd1);
      chk("s5_restart_parado", parado, 32'd0);
      chk("s5_restart_cnt", instr_retiradas, 32'd11);
      // 6: reset in BUSCA, then reset in ESCRITA
      mem_pronto = 1'b0; reset = 1'b1; inicia = 1'b1; tick(); reset = 1'b0; inicia = 1'b0;
      chk("s6a_pc", pc, 32'd0);
      chk("s6a_cnt", instr_retiradas, 32'd0);
      chk("s6a_busca", busca_req, 32'd0);
      inicia = 1'b1; tick(); inicia = 1'b0;
      run_instr(0, 0, 0, 0, 0, 13'd0, 32'd0, 1);
      chk("s6b_cnt1", instr_retiradas, 32'd1);
      mem_pronto = 1'b1; tick();
      jump_al = 1'b1; jalr = 1'b0; halt = 1'b0; escreve_reg_in = 1'b1; alvo_jal = 13'h55; tick();
      chk("s6b_we_before", escreve_reg, 32'd1);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("s6b_we", escreve_reg, 32'd0);
      chk("s6b_sel", sel_jal, 32'd0);
      chk("s6b_pc", pc, 32'd0);
      chk("s6b_cnt", instr_retiradas, 32'd0);
      inicia = 1'b1; tick(); inicia = 1'b0;
      // randomized instruction stream
      for (int n = 0; n < 300; n++) begin
         logic h;
         if ($urandom_range(0, 39) == 0) begin
            mem_pronto = 1'($urandom); inicia = 1'($urandom); reset = 1'b1; tick();
            reset = 1'b0; inicia = 1'b1; tick(); inicia = 1'b0;
         end
         h = ($urandom_range(0, 15) == 0);
         run_instr($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 1'($urandom), h,
                   1'($urandom), AW'($urandom), $urandom, $urandom_range(0, 2));
         if (h) begin
            repeat ($urandom_range(0, 3)) begin mem_pronto = 1'($urandom); junk_dec(); tick(); end
            inicia = 1'b1; tick(); inicia = 1'b0;
         end
      end
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
